// File: rtl/sudoku_pkg.sv
// Shared definitions for the Sudoku board renderer: colours, region classes,
// move-direction encodings and the board cell-index helper.
package sudoku_pkg;

  localparam logic [11:0] BLACK  = 12'h000;
  localparam logic [11:0] WHITE  = 12'hFFF;
  localparam logic [11:0] RED    = 12'hF00;
  localparam logic [11:0] GREEN  = 12'h0F0;
  localparam logic [11:0] BLUE   = 12'h00F;
  localparam logic [11:0] YELLOW = 12'hFF0;

  // Pixel region classes (also used per axis while decoding).
  typedef enum logic [1:0] {
    RG_OUTSIDE = 2'd0,
    RG_THICK   = 2'd1,
    RG_THIN    = 2'd2,
    RG_CELL    = 2'd3
  } region_e;

  // Cursor move directions as driven on move_dir.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  // Result of decoding one screen axis against the board layout.
  typedef struct packed {
    region_e     cls;
    logic [3:0]  idx;
    logic [9:0]  off;
  } axis_t;

  // Flat row-major index of a board cell.
  function automatic logic [6:0] cell_index(input logic [3:0] row, input logic [3:0] col);
    return 7'(row) * 7'd9 + 7'(col);
  endfunction

endpackage

// File: rtl/sudoku_board_renderer_glyph.sv
// Seven-segment glyph hit test for one cell. Segments sit in a box inset
// CELL/6 from the cell edges, with bars CELL/12 thick. Digit 0 draws nothing.
module seven_seg_glyph
  import sudoku_pkg::*;
#(
  parameter int CELL = 48
) (
  input  logic [3:0] digit,
  input  logic [9:0] x_off,
  input  logic [9:0] y_off,
  output logic       hit
);

  localparam logic [9:0] LO  = 10'(CELL / 6);
  localparam logic [9:0] T   = 10'(CELL / 12);
  localparam logic [9:0] HI  = 10'(CELL - CELL / 6);
  localparam logic [9:0] MID = 10'(CELL / 2);
  localparam logic [9:0] MT  = 10'(CELL / 2 - (CELL / 12) / 2);

  // Segment enables {a,b,c,d,e,f,g} for each digit.
  function automatic logic [6:0] seg_mask(input logic [3:0] d);
    case (d)
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  logic [6:0] m;
  logic in_l, in_r, in_h, in_top, in_mid, in_bot, in_up, in_lo;

  // Geometric bands of the glyph box, then OR of the enabled segments.
  always_comb begin
    m      = seg_mask(digit);
    in_l   = (x_off >= LO) && (x_off < LO + T);
    in_r   = (x_off >= HI - T) && (x_off < HI);
    in_h   = (x_off >= LO) && (x_off < HI);
    in_top = (y_off >= LO) && (y_off < LO + T);
    in_mid = (y_off >= MT) && (y_off < MT + T);
    in_bot = (y_off >= HI - T) && (y_off < HI);
    in_up  = (y_off >= LO) && (y_off < MID);
    in_lo  = (y_off >= MID) && (y_off < HI);
    hit    = (m[6] & in_h & in_top) | (m[5] & in_r & in_up) | (m[4] & in_r & in_lo) |
             (m[3] & in_h & in_bot) | (m[2] & in_l & in_lo) | (m[1] & in_l & in_up) |
             (m[0] & in_h & in_mid);
  end

endmodule

// File: rtl/sudoku_board_renderer.sv
// Sudoku board renderer: 9x9 board store with given flags, wrap-around
// cursor, and a 2-stage pixel pipeline painting grid, digits and cursor.
// Optional macro CURSOR_BLINK_EN makes the cursor highlight blink every
// BLINK_FRAMES frames; without it the highlight is solid.
module sudoku_board_renderer
  import sudoku_pkg::*;
#(
  parameter int X0           = 85,
  parameter int Y0           = 5,
  parameter int CELL         = 48,
  parameter int THIN         = 3,
  parameter int THICK        = 5,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  input  logic        wr_valid,
  input  logic [3:0]  wr_digit,
  input  logic        ld_valid,
  input  logic [3:0]  ld_row,
  input  logic [3:0]  ld_col,
  input  logic [3:0]  ld_digit,
  input  logic        clr,
  output logic [11:0] rgb,
  output logic [3:0]  cursor_row,
  output logic [3:0]  cursor_col,
  output logic        wr_err
);

  localparam int W = 4 * THICK + 6 * THIN + 9 * CELL;

  // Classify one coordinate: outside, thick border, thin divider or cell
  // (with cell index and offset). Cell starts are elaboration constants.
  function automatic axis_t axis_decode(input logic [9:0] c, input int org);
    axis_t r;
    int    off;
    int    s;
    r.cls = RG_OUTSIDE;
    r.idx = '0;
    r.off = '0;
    off   = int'(c) - org;
    if (off >= 0 && off < W) begin
      r.cls = RG_THICK;
      for (int i = 0; i < 9; i++) begin
        s = THICK + i * CELL + (i - i / 3) * THIN + (i / 3) * THICK;
        if (off >= s && off < s + CELL) begin
          r.cls = RG_CELL;
          r.idx = 4'(i);
          r.off = 10'(off - s);
        end else if ((i % 3) != 2 && off >= s + CELL && off < s + CELL + THIN) begin
          r.cls = RG_THIN;
        end
      end
    end
    return r;
  endfunction

  // ---------------- control state ----------------
  logic [4:0] cell_q [0:80];
  logic [4:0] cell_d [0:80];
  logic [3:0] cur_row_q, cur_row_d, cur_col_q, cur_col_d;
  logic       wr_err_q, wr_err_d;
  logic       blink_on;
  logic [6:0] cur_idx, ld_idx;
  logic       wr_ok, ld_ok, ld_same;

  // Write/load/clear arbitration and cursor movement.
  always_comb begin
    cur_idx  = cell_index(cur_row_q, cur_col_q);
    ld_idx   = cell_index(ld_row, ld_col);
    ld_same  = ld_valid && (ld_row == cur_row_q) && (ld_col == cur_col_q);
    wr_ok    = wr_valid && (wr_digit <= 4'd9) && !cell_q[cur_idx][4];
    ld_ok    = ld_valid && (ld_row <= 4'd8) && (ld_col <= 4'd8) && (ld_digit <= 4'd9);
    // A write that loses to a load on the same cell is silently dropped.
    wr_err_d = (ld_valid && !ld_ok) || (wr_valid && !wr_ok && !ld_same);
    for (int i = 0; i < 81; i++) begin
      cell_d[i] = cell_q[i];
      if (clr && !cell_q[i][4]) cell_d[i][3:0] = 4'd0;
      if (wr_ok && !ld_same && 7'(i) == cur_idx) cell_d[i] = {1'b0, wr_digit};
      if (ld_ok && 7'(i) == ld_idx) cell_d[i] = {(ld_digit != 4'd0), ld_digit};
    end
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    if (move_valid) begin
      case (move_dir)
        DIR_UP:    cur_row_d = (cur_row_q == 4'd0) ? 4'd8 : cur_row_q - 4'd1;
        DIR_DOWN:  cur_row_d = (cur_row_q == 4'd8) ? 4'd0 : cur_row_q + 4'd1;
        DIR_LEFT:  cur_col_d = (cur_col_q == 4'd0) ? 4'd8 : cur_col_q - 4'd1;
        default:   cur_col_d = (cur_col_q == 4'd8) ? 4'd0 : cur_col_q + 4'd1;
      endcase
    end
  end

  // Board store, cursor and error pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 81; i++) cell_q[i] <= '0;
      cur_row_q <= '0;
      cur_col_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      cell_q    <= cell_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      wr_err_q  <= wr_err_d;
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            blink_on_q, blink_on_d;

  // Frame counter toggles blink at wrap; a move restarts with cursor visible.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (move_valid) begin
      frame_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (hCount == 10'd0 && vCount == 10'd0) begin
      if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  // Blink state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign blink_on = blink_on_q;
`else
  // BLINK_FRAMES is at least 1, so the highlight is permanently on.
  assign blink_on = (BLINK_FRAMES > 0);
`endif

  // ---------------- pixel pipeline ----------------
  region_e    region_p1_q, region_p1_d;
  logic [3:0] row_p1_q, row_p1_d, col_p1_q, col_p1_d;
  logic [9:0] xo_p1_q, xo_p1_d, yo_p1_q, yo_p1_d;
  logic       bright_p1_q, bright_p1_d;
  logic [11:0] rgb_p2_q, rgb_p2_d;
  axis_t      ax, ay;

  // Stage 1: region class, cell coordinates and in-cell offsets.
  always_comb begin
    ax          = axis_decode(hCount, X0);
    ay          = axis_decode(vCount, Y0);
    region_p1_d = RG_CELL;
    if (ax.cls == RG_OUTSIDE || ay.cls == RG_OUTSIDE)   region_p1_d = RG_OUTSIDE;
    else if (ax.cls == RG_THICK || ay.cls == RG_THICK)  region_p1_d = RG_THICK;
    else if (ax.cls == RG_THIN || ay.cls == RG_THIN)    region_p1_d = RG_THIN;
    row_p1_d    = ay.idx;
    col_p1_d    = ax.idx;
    xo_p1_d     = ax.off;
    yo_p1_d     = ay.off;
    bright_p1_d = bright;
  end

  // Stage 1 registers, cleared to "outside, not bright".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      region_p1_q <= RG_OUTSIDE;
      row_p1_q    <= '0;
      col_p1_q    <= '0;
      xo_p1_q     <= '0;
      yo_p1_q     <= '0;
      bright_p1_q <= 1'b0;
    end else begin
      region_p1_q <= region_p1_d;
      row_p1_q    <= row_p1_d;
      col_p1_q    <= col_p1_d;
      xo_p1_q     <= xo_p1_d;
      yo_p1_q     <= yo_p1_d;
      bright_p1_q <= bright_p1_d;
    end
  end

  logic [4:0] pix_cell;
  logic       glyph_hit;

  assign pix_cell = cell_q[cell_index(row_p1_q, col_p1_q)];

  seven_seg_glyph #(.CELL(CELL)) u_glyph (
    .digit (pix_cell[3:0]),
    .x_off (xo_p1_q),
    .y_off (yo_p1_q),
    .hit   (glyph_hit)
  );

  // Stage 2: glyph hit and colour priority.
  always_comb begin
    rgb_p2_d = BLUE;
    if (!bright_p1_q) begin
      rgb_p2_d = BLACK;
    end else begin
      case (region_p1_q)
        RG_THICK, RG_THIN: rgb_p2_d = BLACK;
        RG_CELL: begin
          if (glyph_hit)
            rgb_p2_d = pix_cell[4] ? BLACK : BLUE;
          else if (blink_on && row_p1_q == cur_row_q && col_p1_q == cur_col_q)
            rgb_p2_d = YELLOW;
          else
            rgb_p2_d = WHITE;
        end
        default: rgb_p2_d = BLUE;
      endcase
    end
  end

  // Stage 2 output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rgb_p2_q <= BLACK;
    else        rgb_p2_q <= rgb_p2_d;
  end

  assign rgb        = rgb_p2_q;
  assign cursor_row = cur_row_q;
  assign cursor_col = cur_col_q;
  assign wr_err     = wr_err_q;

endmodule
